wb_arbiter_2m: RTL
==================

Name: wb_arbiter_2m

Overview:
Two-master Wishbone arbiter with a bus watchdog, sitting between the 16-bit Wishbone masters (byte-serial command bridge, debug/controller master) and the shared monitor Wishbone slave bus. Masters issue a one-cycle cyc/stb request pulse, then wait for a one-cycle ack or timeout pulse. The block latches each request, grants the bus round-robin and drives held cyc/stb to the slaves. It routes ack/read data back to the originator, or aborts the cycle and returns a timeout.

Parameters:
TIMEOUT_W, 16, width of watchdog counter
TIMEOUT, 1000, cycles s_cyc_o may stay high without ack before abort (1..2^TIMEOUT_W-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
m0_cyc_i  in  1  master 0 request pulse (with stb)
m0_stb_i  in  1  master 0 strobe
m0_we_i  in  1  master 0 write enable
m0_adr_i  in  16  master 0 address
m0_dat_i  in  16  master 0 write data
m0_dat_o  out  16  master 0 read data
m0_ack_o  out  1  master 0 ack pulse
m0_timeout_o  out  1  master 0 timeout pulse
m1_*  same set as m0_* for master 1
s_cyc_o  out  1  slave bus cycle
s_stb_o  out  1  slave bus strobe
s_we_o  out  1  slave write enable
s_adr_o  out  16  slave address
s_dat_o  out  16  slave write data
s_dat_i  in  16  slave read data
s_ack_i  in  1  slave ack

Behaviour:
- Clock and reset: clk, rising edge; reset synchronous, active-high.
- Reset values:
  - All outputs 0.
  - pend[1:0]=0, state=IDLE, last_grant=1, so master 0 wins the first contention.
  - Reset mid-transaction drops s_cyc_o/s_stb_o the next edge, discards pending requests and emits no ack or timeout.
- Capture:
  - mi_cyc_i & mi_stb_i high for one cycle latches adr/dat/we into slot i and sets pend[i].
  - A pulse while pend[i]=1 (queued or active) is ignored; slot contents are unchanged.
- State IDLE:
  - If pend==0, stay.
  - If exactly one pend bit is set, grant that master.
  - If both are set, grant ~last_grant.
  - On grant, the next edge sets s_cyc_o=s_stb_o=1 and loads s_we_o/s_adr_o/s_dat_o from the granted slot, clears the counter, sets gnt, and moves to BUS.
  - A request is checked in IDLE only after its pend bit is registered. A pulse at cycle n therefore sets pend at n+1 and s_cyc_o is high from n+2.
- State BUS: s_cyc_o, s_stb_o and the slot fields are held constant. The counter increments each cycle.
- State BUS, s_ack_i=1:
  - Next edge: mg_ack_o=1 for one cycle.
  - mg_dat_o<=s_dat_i; load it on writes too.
  - s_cyc_o=s_stb_o=0, pend[g]=0, last_grant<=g, state=IDLE.
- State BUS, counter==TIMEOUT-1 with no ack (s_cyc_o has been high TIMEOUT cycles):
  - Next edge: mg_timeout_o=1 for one cycle.
  - s_cyc_o=s_stb_o=0, pend[g]=0, last_grant<=g, state=IDLE.
  - mg_dat_o is unchanged.
- Ack and timeout on the same cycle: ack wins and no timeout pulse is produced.
- Minimum one IDLE cycle between consecutive bus cycles (s_cyc_o low for at least 1 cycle).
- s_ack_i while in IDLE is ignored.
- Each ack or timeout pulse goes to exactly one master. Pulses never overlap, and ack/timeout are never both high on the same master.
- mi_dat_o holds its value until the next successful ack for that master.
- s_we_o, s_adr_o and s_dat_o may keep stale values in IDLE; they are valid only while s_cyc_o=1.

Test Plan:
- Single read: m0 pulse at cycle 0 with adr=0x1234, we=0; slave acks at cycle 5 with 0xBEEF.
  -> s_cyc_o high for cycles 2..5, s_adr_o=0x1234, m0_ack_o pulse at cycle 6, m0_dat_o=0xBEEF, m1 outputs stay 0.
- Simultaneous requests after reset: m0 write (0x0010, 0xAAAA) and m1 write (0x0020, 0x5555) pulsed the same cycle; slave acks each after 1 cycle.
  -> m0 is served first, then s_cyc_o is low for at least 1 cycle, then the m1 cycle runs. Each master gets exactly one ack.
- Fairness: both masters re-request immediately after every ack for 20 transactions.
  -> Grants alternate m0, m1, m0, ...; each master gets 10 acks.
- Timeout: TIMEOUT=8, m1 read with slave never acking.
  -> s_cyc_o high for exactly 8 cycles, m1_timeout_o one-cycle pulse, m1_dat_o unchanged, then a new m0 request completes normally.
- Boundary: s_ack_i asserted on the 8th cycle of s_cyc_o (TIMEOUT=8).
  -> ack pulse only, no timeout; a duplicate m0 pulse during BUS is ignored (one slave cycle only).
- Reset asserted mid-BUS with m1 pending.
  -> All outputs 0 the next cycle, no ack/timeout, pend cleared, and the first post-reset contention grants m0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter with round-robin grant and a bus watchdog.
// Each master request pulse is latched into a slot and replayed as a held cycle on the slave bus.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [15:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_timeout_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [15:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_timeout_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [15:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBus  = 1'b1;

  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT - 1);

  // Per-master request view, index 0 = m0, index 1 = m1
  logic [1:0]       req;
  logic [1:0]       m_we;
  logic [1:0][15:0] m_adr;
  logic [1:0][15:0] m_dat;

  assign req   = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign m_we  = {m1_we_i, m0_we_i};
  assign m_adr = {m1_adr_i, m0_adr_i};
  assign m_dat = {m1_dat_i, m0_dat_i};

  logic [0:0]           state_q, state_d;
  logic [1:0]           pend_q, pend_d;
  logic                 last_grant_q, last_grant_d;
  logic                 gnt_q, gnt_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic [1:0]           slot_we_q, slot_we_d;
  logic [1:0][15:0]     slot_adr_q, slot_adr_d;
  logic [1:0][15:0]     slot_dat_q, slot_dat_d;

  logic                 s_cyc_q, s_cyc_d;
  logic                 s_we_q, s_we_d;
  logic [15:0]          s_adr_q, s_adr_d;
  logic [15:0]          s_dat_q, s_dat_d;

  logic [1:0]           ack_q, ack_d;
  logic [1:0]           tmo_q, tmo_d;
  logic [1:0][15:0]     rdat_q, rdat_d;

  logic                 grant_sel;

  // Round-robin only matters on contention; a lone request is granted directly.
  always_comb begin
    grant_sel = 1'b0;
    if (pend_q == 2'b11) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = pend_q[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    slot_we_d    = slot_we_q;
    slot_adr_d   = slot_adr_q;
    slot_dat_d   = slot_dat_q;
    s_cyc_d      = s_cyc_q;
    s_we_d       = s_we_q;
    s_adr_d      = s_adr_q;
    s_dat_d      = s_dat_q;
    ack_d        = 2'b00;
    tmo_d        = 2'b00;
    rdat_d       = rdat_q;

    // A pulse while the slot is busy (queued or on the bus) is dropped.
    for (int i = 0; i < 2; i++) begin
      if (req[i] && !pend_q[i]) begin
        pend_d[i]     = 1'b1;
        slot_we_d[i]  = m_we[i];
        slot_adr_d[i] = m_adr[i];
        slot_dat_d[i] = m_dat[i];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pend_q != 2'b00) begin
          gnt_d   = grant_sel;
          s_cyc_d = 1'b1;
          s_we_d  = slot_we_q[grant_sel];
          s_adr_d = slot_adr_q[grant_sel];
          s_dat_d = slot_dat_q[grant_sel];
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        cnt_d = cnt_q + 1'b1;
        if (s_ack_i) begin
          ack_d[gnt_q]  = 1'b1;
          rdat_d[gnt_q] = s_dat_i;
          s_cyc_d       = 1'b0;
          pend_d[gnt_q] = 1'b0;
          last_grant_d  = gnt_q;
          state_d       = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          tmo_d[gnt_q]  = 1'b1;
          s_cyc_d       = 1'b0;
          pend_d[gnt_q] = 1'b0;
          last_grant_d  = gnt_q;
          state_d       = StIdle;
        end
      end
      default: begin
        s_cyc_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_q       <= 2'b00;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      cnt_q        <= '0;
      slot_we_q    <= '0;
      slot_adr_q   <= '0;
      slot_dat_q   <= '0;
      s_cyc_q      <= 1'b0;
      s_we_q       <= 1'b0;
      s_adr_q      <= '0;
      s_dat_q      <= '0;
      ack_q        <= 2'b00;
      tmo_q        <= 2'b00;
      rdat_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      slot_we_q    <= slot_we_d;
      slot_adr_q   <= slot_adr_d;
      slot_dat_q   <= slot_dat_d;
      s_cyc_q      <= s_cyc_d;
      s_we_q       <= s_we_d;
      s_adr_q      <= s_adr_d;
      s_dat_q      <= s_dat_d;
      ack_q        <= ack_d;
      tmo_q        <= tmo_d;
      rdat_q       <= rdat_d;
    end
  end

  assign s_cyc_o      = s_cyc_q;
  assign s_stb_o      = s_cyc_q;
  assign s_we_o       = s_we_q;
  assign s_adr_o      = s_adr_q;
  assign s_dat_o      = s_dat_q;

  assign m0_dat_o     = rdat_q[0];
  assign m0_ack_o     = ack_q[0];
  assign m0_timeout_o = tmo_q[0];
  assign m1_dat_o     = rdat_q[1];
  assign m1_ack_o     = ack_q[1];
  assign m1_timeout_o = tmo_q[1];

endmodule
